wb_stage: RTL and testbench

- MEM/WB pipeline register and write-back stage of the pipelined CPU.
- Latches memory-stage results and formats load data (byte/half extraction, sign/zero extension).
- Selects the write-back source and drives the register file write port (we3/addr3/write3).
- Exports the write-back destination and data to the forwarding/hazard logic.

---
 rtl/wb_stage_if.sv | 37 +++
 rtl/wb_stage.sv | 134 +++++++++++++
 tb/tb_wb_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM->WB boundary bundle: memory-stage results in, register-file write port and
// forwarding taps out. wb_stage connects to the slave modport.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  // MEM stage -> WB stage
  logic            mem_valid;
  logic            mem_reg_we;
  logic [4:0]      mem_rd_addr;
  logic [1:0]      mem_wb_sel;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_data;
  logic [1:0]      mem_load_size;
  logic            mem_load_unsigned;
  logic [XLEN-1:0] mem_pc_plus4;

  // WB stage -> register file / hazard unit
  logic            reg_we;
  logic [4:0]      reg_addr;
  logic [XLEN-1:0] reg_wdata;
  logic            wb_valid;
  logic            wb_fwd_we;
  logic [4:0]      wb_fwd_addr;
  logic [XLEN-1:0] wb_fwd_data;

  modport master (
    output mem_valid, mem_reg_we, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_unsigned, mem_pc_plus4,
    input  reg_we, reg_addr, reg_wdata, wb_valid, wb_fwd_we, wb_fwd_addr, wb_fwd_data
  );

  modport slave (
    input  mem_valid, mem_reg_we, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_unsigned, mem_pc_plus4,
    output reg_we, reg_addr, reg_wdata, wb_valid, wb_fwd_we, wb_fwd_addr, wb_fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: load formatting, write-back mux,
// register-file write port and forwarding taps. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                flush,
  wb_stage_if.slave           bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } load_size_e;

  logic            valid_q;
  logic            reg_we_q;
  logic [4:0]      rd_q;
  wb_sel_e         sel_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] load_data_q;
  load_size_e      size_q;
  logic            unsigned_q;
  logic [XLEN-1:0] pc4_q;
  logic            done_q;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] wb_data;
  logic            writes_rd;

  // done marks an instruction that already spent one cycle in WB while stalled.
  // Setting it on any resident instruction (not only writing ones) leaves reg_we
  // unchanged and makes the retire counter count stalled instructions once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      rd_q        <= '0;
      sel_q       <= SEL_ALU;
      alu_q       <= '0;
      load_data_q <= '0;
      size_q      <= SIZE_BYTE;
      unsigned_q  <= 1'b0;
      pc4_q       <= '0;
      done_q      <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall) begin
      done_q <= done_q | valid_q;
    end else begin
      valid_q     <= bus.mem_valid;
      reg_we_q    <= bus.mem_reg_we;
      rd_q        <= bus.mem_rd_addr;
      sel_q       <= wb_sel_e'(bus.mem_wb_sel);
      alu_q       <= bus.mem_alu_result;
      load_data_q <= bus.mem_load_data;
      size_q      <= load_size_e'(bus.mem_load_size);
      unsigned_q  <= bus.mem_load_unsigned;
      pc4_q       <= bus.mem_pc_plus4;
      done_q      <= 1'b0;
    end
  end

  always_comb begin
    byte_lane = '0;
    case (alu_q[1:0])
      2'd0:    byte_lane = load_data_q[7:0];
      2'd1:    byte_lane = load_data_q[15:8];
      2'd2:    byte_lane = load_data_q[23:16];
      default: byte_lane = load_data_q[31:24];
    endcase
    half_lane = alu_q[1] ? load_data_q[31:16] : load_data_q[15:0];
  end

  always_comb begin
    load_fmt = load_data_q;
    case (size_q)
      SIZE_BYTE: load_fmt = unsigned_q ? {{(XLEN-8){1'b0}}, byte_lane}
                                       : {{(XLEN-8){byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_fmt = unsigned_q ? {{(XLEN-16){1'b0}}, half_lane}
                                       : {{(XLEN-16){half_lane[15]}}, half_lane};
      default:   load_fmt = load_data_q;
    endcase
  end

  always_comb begin
    wb_data = alu_q;
    case (sel_q)
      SEL_LOAD: wb_data = load_fmt;
      SEL_PC4:  wb_data = pc4_q;
      default:  wb_data = alu_q;
    endcase
  end

  assign writes_rd = valid_q & reg_we_q & (rd_q != 5'd0);

  assign bus.wb_valid    = valid_q;
  assign bus.reg_we      = writes_rd & ~done_q;
  assign bus.reg_addr    = valid_q ? rd_q : 5'd0;
  assign bus.reg_wdata   = valid_q ? wb_data : '0;
  assign bus.wb_fwd_we   = writes_rd;
  assign bus.wb_fwd_addr = bus.reg_addr;
  assign bus.wb_fwd_data = bus.reg_wdata;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (valid_q && !done_q && !flush) begin
      retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: one task per scenario, inline checks.
module tb_wb_stage;

  logic clk;
  logic reset_n;
  logic stall;
  logic flush;
  int unsigned total;
  int unsigned passed;

  logic [31:0] rf [32];
  int unsigned x7_writes;

  wb_stage_if #(.XLEN(32)) bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [3:0] retire_cnt;
  logic [3:0] cnt_snap;
`endif

  wb_stage #(
    .XLEN(32),
    .RETIRE_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .flush(flush),
    .bus(bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed from the write port
  always @(posedge clk) begin
    if (bus.reg_we) begin
      rf[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_addr == 5'd7) x7_writes <= x7_writes + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] data, input logic [1:0] size,
                       input logic uns, input logic [31:0] pc4);
    bus.mem_valid         = v;
    bus.mem_reg_we        = we;
    bus.mem_rd_addr       = rd;
    bus.mem_wb_sel        = sel;
    bus.mem_alu_result    = alu;
    bus.mem_load_data     = data;
    bus.mem_load_size     = size;
    bus.mem_load_unsigned = uns;
    bus.mem_pc_plus4      = pc4;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'hDEAD_BEEF, '0, 2'b10, 1'b0, '0);
    tick();
    tick();
    total++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.wb_valid); else passed++;
    total++; if (bus.reg_we !== 1'b0) $display("FAIL reset_we got %0b want 0", bus.reg_we); else passed++;
    total++; if (bus.reg_addr !== 5'd0) $display("FAIL reset_addr got %0d want 0", bus.reg_addr); else passed++;
    total++; if (bus.reg_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.reg_wdata); else passed++;
    total++; if (bus.wb_fwd_we !== 1'b0 || bus.wb_fwd_addr !== 5'd0 || bus.wb_fwd_data !== 32'h0)
      $display("FAIL reset_fwd got %0b/%0d/%h want 0/0/0", bus.wb_fwd_we, bus.wb_fwd_addr, bus.wb_fwd_data);
    else passed++;
`ifdef WB_RETIRE_CNT_EN
    total++; if (retire_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", retire_cnt); else passed++;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
  endtask

  task automatic test_alu;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h100);
    tick();
    total++; if (bus.reg_we !== 1'b1) $display("FAIL alu_we got %0b want 1", bus.reg_we); else passed++;
    total++; if (bus.reg_addr !== 5'd5) $display("FAIL alu_addr got %0d want 5", bus.reg_addr); else passed++;
    total++; if (bus.reg_wdata !== 32'h1234_5678) $display("FAIL alu_wdata got %h want 12345678", bus.reg_wdata); else passed++;
    total++; if (bus.wb_fwd_we !== 1'b1 || bus.wb_fwd_addr !== 5'd5 || bus.wb_fwd_data !== 32'h1234_5678)
      $display("FAIL alu_fwd got %0b/%0d/%h want 1/5/12345678", bus.wb_fwd_we, bus.wb_fwd_addr, bus.wb_fwd_data);
    else passed++;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
    total++; if (rf[5] !== 32'h1234_5678) $display("FAIL alu_rf_x5 got %h want 12345678", rf[5]); else passed++;
    total++; if (bus.reg_wdata !== 32'h0 || bus.reg_addr !== 5'd0) $display("FAIL bubble_zero got %h/%0d want 0/0", bus.reg_wdata, bus.reg_addr); else passed++;
  endtask

  task automatic test_load_format;
    logic [1:0]  sz  [9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11};
    logic        un  [9] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    logic [31:0] adr [9] = '{32'h1003, 32'h1001, 32'h1002, 32'h1003, 32'h1002,
                             32'h1000, 32'h1002, 32'h1000, 32'h1001};
    logic [31:0] exp [9] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF,
                             32'h80FF_7F01, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_7F01,
                             32'h80FF_7F01};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 5'd6, 2'b01, adr[i], 32'h80FF_7F01, sz[i], un[i], 32'h200);
      tick();
      total++;
      if (bus.reg_wdata !== exp[i]) $display("FAIL load_fmt[%0d] got %h want %h", i, bus.reg_wdata, exp[i]);
      else passed++;
    end
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
  endtask

  task automatic test_rd_zero_and_sel;
    drive(1'b1, 1'b1, 5'd0, 2'b10, 32'h55, '0, 2'b10, 1'b0, 32'h40);
    tick();
    total++; if (bus.reg_we !== 1'b0) $display("FAIL rd0_we got %0b want 0", bus.reg_we); else passed++;
    total++; if (bus.wb_fwd_we !== 1'b0) $display("FAIL rd0_fwd_we got %0b want 0", bus.wb_fwd_we); else passed++;
    total++; if (bus.wb_fwd_data !== 32'h40) $display("FAIL rd0_fwd_data got %h want 00000040", bus.wb_fwd_data); else passed++;
    drive(1'b1, 1'b1, 5'd9, 2'b11, 32'hCAFE_0001, 32'h1111_1111, 2'b10, 1'b0, 32'h44);
    tick();
    total++; if (bus.reg_wdata !== 32'hCAFE_0001) $display("FAIL sel_rsvd got %h want cafe0001", bus.reg_wdata); else passed++;
    drive(1'b1, 1'b0, 5'd9, 2'b10, 32'h1, '0, 2'b10, 1'b0, 32'h48);
    tick();
    total++; if (bus.reg_we !== 1'b0 || bus.wb_fwd_we !== 1'b0 || bus.reg_wdata !== 32'h48)
      $display("FAIL no_we got %0b/%0b/%h want 0/0/00000048", bus.reg_we, bus.wb_fwd_we, bus.reg_wdata);
    else passed++;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
  endtask

  task automatic test_stall;
    int unsigned w0;
    w0 = x7_writes;
    drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h0000_0777, '0, 2'b10, 1'b0, '0);
    tick();
`ifdef WB_RETIRE_CNT_EN
    cnt_snap = retire_cnt;
`endif
    total++; if (bus.reg_we !== 1'b1 || bus.wb_fwd_we !== 1'b1) $display("FAIL stall_c0 got we %0b fwd %0b want 1/1", bus.reg_we, bus.wb_fwd_we); else passed++;
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0999, '0, 2'b10, 1'b0, '0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (bus.reg_we !== 1'b0 || bus.wb_fwd_we !== 1'b1 || bus.reg_addr !== 5'd7 || bus.reg_wdata !== 32'h777)
        $display("FAIL stall_c%0d got we %0b fwd %0b addr %0d data %h want 0/1/7/00000777",
                 c, bus.reg_we, bus.wb_fwd_we, bus.reg_addr, bus.reg_wdata);
      else passed++;
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
    total++; if (x7_writes - w0 !== 1) $display("FAIL stall_writes got %0d want 1", x7_writes - w0); else passed++;
`ifdef WB_RETIRE_CNT_EN
    total++; if (retire_cnt !== cnt_snap + 4'd1) $display("FAIL stall_cnt got %0d want %0d", retire_cnt, cnt_snap + 4'd1); else passed++;
`endif
  endtask

  task automatic test_flush_stall;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h0000_0333, '0, 2'b10, 1'b0, '0);
    tick();
    total++; if (bus.reg_we !== 1'b1) $display("FAIL flush_pre_we got %0b want 1", bus.reg_we); else passed++;
`ifdef WB_RETIRE_CNT_EN
    cnt_snap = retire_cnt;
`endif
    flush = 1'b1;
    stall = 1'b1;
    tick();
    total++;
    if (bus.wb_valid !== 1'b0 || bus.reg_we !== 1'b0 || bus.wb_fwd_we !== 1'b0 || bus.reg_wdata !== 32'h0)
      $display("FAIL flush_stall got v %0b we %0b fwd %0b data %h want 0/0/0/0",
               bus.wb_valid, bus.reg_we, bus.wb_fwd_we, bus.reg_wdata);
    else passed++;
`ifdef WB_RETIRE_CNT_EN
    total++; if (retire_cnt !== cnt_snap) $display("FAIL flush_cnt got %0d want %0d", retire_cnt, cnt_snap); else passed++;
`endif
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h0000_7777, '0, 2'b10, 1'b0, '0);
    tick();
    stall = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.reg_we !== 1'b0 || bus.reg_addr !== 5'd0 || bus.reg_wdata !== 32'h0 || bus.wb_valid !== 1'b0)
      $display("FAIL async_reset got we %0b addr %0d data %h v %0b want 0/0/0/0",
               bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.wb_valid);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd10, 2'b00, 32'h0000_ABCD, '0, 2'b10, 1'b0, '0);
    tick();
    total++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 5'd10 || bus.reg_wdata !== 32'hABCD)
      $display("FAIL post_reset got we %0b addr %0d data %h want 1/10/0000abcd", bus.reg_we, bus.reg_addr, bus.reg_wdata);
    else passed++;
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
    total++; if (rf[10] !== 32'hABCD) $display("FAIL post_reset_rf got %h want 0000abcd", rf[10]); else passed++;
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_wrap;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // 17 retires (including rd=0 and non-writing ones) on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, (i % 3) != 0, 5'(i), 2'b00, 32'(i), '0, 2'b10, 1'b0, '0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, '0);
    tick();
    total++; if (retire_cnt !== 4'd1) $display("FAIL retire_wrap got %0d want 1", retire_cnt); else passed++;
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    x7_writes = 0;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    test_reset();
    test_alu();
    test_load_format();
    test_rd_zero_and_sel();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
`ifdef WB_RETIRE_CNT_EN
    test_retire_wrap();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
